// File: rtl/pwm_seq_pkg.sv
// Shared types for the streamed PWM sequencer: loader FSM states and per-channel edge record.
package pwm_seq_pkg;

  localparam int PWM_WIDTH = 13;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_PENDING = 2'd2
  } seq_state_t;

  // One channel's switching points within a period; full forces the output high.
  typedef struct packed {
    logic [PWM_WIDTH-1:0] rise;
    logic [PWM_WIDTH-1:0] fall;
    logic                 full;
  } pwm_edge_t;

endpackage

// File: rtl/pwm_edge_calc.sv
// Two-stage edge arithmetic: stage 1 clamps duty/phase to the frame period,
// stage 2 forms rise/fall with a single conditional wrap per edge.
module pwm_edge_calc
  import pwm_seq_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int IDX_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_last,
  input  logic [IDX_W-1:0] i_ch,
  input  logic [WIDTH-1:0] i_cycle,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_duty,
  input  logic [WIDTH-1:0] i_phase,
  output logic             o_valid,
  output logic             o_last,
  output logic [IDX_W-1:0] o_ch,
  output pwm_edge_t        o_edge
);

  logic             r_s1Valid;
  logic             r_s1Last;
  logic [IDX_W-1:0] r_s1Ch;
  logic [WIDTH-1:0] r_s1Cycle;
  logic             r_s1Mode;
  logic [WIDTH-1:0] r_s1Duty;
  logic [WIDTH-1:0] r_s1Phase;

  logic [WIDTH-1:0] w_phaseMax;
  logic [WIDTH-1:0] w_dutyClamp;
  logic [WIDTH-1:0] w_phaseClamp;
  logic [WIDTH:0]   w_cycleExt;
  logic [WIDTH:0]   w_halfDown;
  logic [WIDTH:0]   w_halfUp;
  logic [WIDTH:0]   w_sumEdge;
  logic [WIDTH:0]   w_sumRise;
  logic [WIDTH:0]   w_sumFall;
  pwm_edge_t        w_edge;

  // All operands stay below 2C, so one subtraction is a full modulo.
  function automatic logic [WIDTH-1:0] wrapOnce(input logic [WIDTH:0] s, input logic [WIDTH:0] c);
    return (s >= c) ? WIDTH'(s - c) : s[WIDTH-1:0];
  endfunction

  assign w_phaseMax   = i_cycle - WIDTH'(1);
  assign w_dutyClamp  = (i_duty > i_cycle) ? i_cycle : i_duty;
  assign w_phaseClamp = (i_phase > w_phaseMax) ? w_phaseMax : i_phase;

  // Stage 1 control: beat-valid tracking, cleared by reset so partial frames vanish.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1Valid <= 1'b0;
      r_s1Last  <= 1'b0;
    end else begin
      r_s1Valid <= i_valid;
      r_s1Last  <= i_valid & i_last;
    end
  end

  // Stage 1 data: clamped operands and the period/mode they belong to.
  always_ff @(posedge i_clk) begin
    r_s1Ch    <= i_ch;
    r_s1Cycle <= i_cycle;
    r_s1Mode  <= i_mode;
    r_s1Duty  <= w_dutyClamp;
    r_s1Phase <= w_phaseClamp;
  end

  assign w_cycleExt = {1'b0, r_s1Cycle};
  assign w_halfDown = {2'b0, r_s1Duty[WIDTH-1:1]};
  assign w_halfUp   = w_halfDown + {{WIDTH{1'b0}}, r_s1Duty[0]};
  assign w_sumEdge  = {1'b0, r_s1Phase} + {1'b0, r_s1Duty};
  assign w_sumRise  = {1'b0, r_s1Phase} + w_cycleExt - w_halfDown;
  assign w_sumFall  = {1'b0, r_s1Phase} + w_halfUp;

  // Center mode splits the duty around the phase point; edge mode starts at the phase.
  always_comb begin
    w_edge = '0;
    if (r_s1Mode) begin
      w_edge.rise = wrapOnce(w_sumRise, w_cycleExt);
      w_edge.fall = wrapOnce(w_sumFall, w_cycleExt);
    end else begin
      w_edge.rise = r_s1Phase;
      w_edge.fall = wrapOnce(w_sumEdge, w_cycleExt);
    end
    w_edge.full = (r_s1Duty == r_s1Cycle);
  end

  // Stage 2 control: result-valid and end-of-frame marker.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      o_valid <= r_s1Valid;
      o_last  <= r_s1Valid & r_s1Last;
    end
  end

  // Stage 2 data: finished edge record and its destination channel.
  always_ff @(posedge i_clk) begin
    o_ch   <= r_s1Ch;
    o_edge <= w_edge;
  end

endmodule

// File: rtl/pwm_seq_engine.sv
// Streamed PWM engine: one channel per beat into a shadow bank, atomic commit
// of edges and period at the period boundary, registered per-channel outputs.
module pwm_seq_engine
  import pwm_seq_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH,
  parameter int CH_NUM = 249
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SYNC,
  input  logic [WIDTH-1:0]  CYCLE,
  input  logic              MODE,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  input  logic [WIDTH-1:0]  DIN_DUTY,
  input  logic [WIDTH-1:0]  DIN_PHASE,
  output logic              UPDATE_PENDING,
  output logic [WIDTH-1:0]  TIME_CNT,
  output logic [CH_NUM-1:0] PWM_OUT
);

  localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  seq_state_t       r_state;
  seq_state_t       w_stateNext;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_cycleS;
  logic             r_modeS;
  logic [WIDTH-1:0] r_timeCnt;
  logic [WIDTH-1:0] r_ca;
  logic [WIDTH-1:0] r_caShd;
  pwm_edge_t        r_shd [CH_NUM];
  pwm_edge_t        r_act [CH_NUM];
  logic [CH_NUM-1:0] r_pwm;
  logic [CH_NUM-1:0] w_pwmNext;

  logic             w_accept;
  logic             w_firstBeat;
  logic             w_lastBeat;
  logic [WIDTH-1:0] w_cycleUse;
  logic             w_modeUse;
  logic             w_wrap;
  logic             w_commit;
  logic             w_wrValid;
  logic             w_wrLast;
  logic [IDX_W-1:0] w_wrCh;
  pwm_edge_t        w_wrEdge;

  assign w_accept    = DIN_VALID & DIN_READY;
  assign w_firstBeat = (r_idx == '0);
  assign w_lastBeat  = (r_idx == IDX_W'(CH_NUM - 1));
  assign w_cycleUse  = w_firstBeat ? CYCLE : r_cycleS;
  assign w_modeUse   = w_firstBeat ? MODE : r_modeS;
  assign w_wrap      = (r_timeCnt == r_ca - WIDTH'(1));
  assign w_commit    = (r_state == ST_PENDING) & (SYNC | w_wrap);

  pwm_edge_calc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_edgeCalc (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_valid (w_accept),
    .i_last  (w_lastBeat),
    .i_ch    (r_idx),
    .i_cycle (w_cycleUse),
    .i_mode  (w_modeUse),
    .i_duty  (DIN_DUTY),
    .i_phase (DIN_PHASE),
    .o_valid (w_wrValid),
    .o_last  (w_wrLast),
    .o_ch    (w_wrCh),
    .o_edge  (w_wrEdge)
  );

  // Loader state register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_LOAD;
    else     r_state <= w_stateNext;
  end

  // Loader next state: accept beats, wait for the pipeline to drain, then hold until commit.
  always_comb begin
    w_stateNext    = r_state;
    DIN_READY      = 1'b0;
    UPDATE_PENDING = 1'b0;
    case (r_state)
      ST_LOAD: begin
        DIN_READY = 1'b1;
        if (DIN_VALID && w_lastBeat) w_stateNext = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_wrValid && w_wrLast) w_stateNext = ST_PENDING;
      end
      ST_PENDING: begin
        UPDATE_PENDING = 1'b1;
        if (w_commit) w_stateNext = ST_LOAD;
      end
      default: w_stateNext = ST_LOAD;
    endcase
  end

  // Channel index advances per accepted beat; the first beat latches the frame's period and mode.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx    <= '0;
      r_cycleS <= WIDTH'(2);
      r_modeS  <= 1'b0;
      r_caShd  <= WIDTH'(2);
    end else if (w_accept) begin
      r_idx <= w_lastBeat ? '0 : r_idx + IDX_W'(1);
      if (w_firstBeat) begin
        r_cycleS <= CYCLE;
        r_modeS  <= MODE;
        r_caShd  <= CYCLE;
      end
    end
  end

  // Shared period counter; the active period switches together with the edges on commit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_timeCnt <= '0;
      r_ca      <= WIDTH'(2);
    end else begin
      r_timeCnt <= (SYNC || w_wrap) ? '0 : r_timeCnt + WIDTH'(1);
      if (w_commit) r_ca <= r_caShd;
    end
  end

  // Shadow bank fills from the pipeline; the whole bank moves to active in one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_shd[i] <= '0;
        r_act[i] <= '0;
      end
    end else begin
      if (w_wrValid) r_shd[w_wrCh] <= w_wrEdge;
      if (w_commit)  r_act <= r_shd;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    assign w_pwmNext[g] =
      r_act[g].full                    ? 1'b1 :
      (r_act[g].rise == r_act[g].fall) ? 1'b0 :
      (r_act[g].rise <  r_act[g].fall) ? ((r_timeCnt >= r_act[g].rise) && (r_timeCnt < r_act[g].fall)) :
                                         ((r_timeCnt >= r_act[g].rise) || (r_timeCnt < r_act[g].fall));
  end

  // Output register: one cycle behind the counter and active edges it was computed from.
  always_ff @(posedge CLK) begin
    if (RST) r_pwm <= '0;
    else     r_pwm <= w_pwmNext;
  end

  assign TIME_CNT = r_timeCnt;
  assign PWM_OUT  = r_pwm;

endmodule

// File: tb/tb_pwm_seq_engine.sv
// Bench for pwm_seq_engine: random frames checked cycle by cycle against a
// behavioural model built from the frame/commit/output rules with plain arithmetic.
module tb_pwm_seq_engine;

  localparam int WIDTH  = 13;
  localparam int CH_NUM = 249;

  logic              CLK = 1'b0;
  logic              RST;
  logic              SYNC;
  logic [WIDTH-1:0]  CYCLE;
  logic              MODE;
  logic              DIN_VALID;
  logic              DIN_READY;
  logic [WIDTH-1:0]  DIN_DUTY;
  logic [WIDTH-1:0]  DIN_PHASE;
  logic              UPDATE_PENDING;
  logic [WIDTH-1:0]  TIME_CNT;
  logic [CH_NUM-1:0] PWM_OUT;

  pwm_seq_engine #(
    .WIDTH  (WIDTH),
    .CH_NUM (CH_NUM)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .SYNC           (SYNC),
    .CYCLE          (CYCLE),
    .MODE           (MODE),
    .DIN_VALID      (DIN_VALID),
    .DIN_READY      (DIN_READY),
    .DIN_DUTY       (DIN_DUTY),
    .DIN_PHASE      (DIN_PHASE),
    .UPDATE_PENDING (UPDATE_PENDING),
    .TIME_CNT       (TIME_CNT),
    .PWM_OUT        (PWM_OUT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  int mT, mPrevT, mCa, mShdCa, mIdx, mCs, mDrainLeft;
  bit mMs, mPending, modelOn = 1'b0;
  int mShdR [CH_NUM];
  int mShdF [CH_NUM];
  bit mShdFull [CH_NUM];
  int mActR [CH_NUM];
  int mActF [CH_NUM];
  bit mActFull [CH_NUM];
  bit [CH_NUM-1:0] mPwm;

  function automatic bit pwmHigh(input int r, input int f, input bit full, input int t, input int c);
    if (full) return 1'b1;
    if (r == f) return 1'b0;
    return ((t - r + c) % c) < ((f - r + c) % c);
  endfunction

  task automatic calcEdge(input int duty, input int phase, input int c, input bit m,
                          output int r, output int f, output bit full);
    int d, p;
    d = (duty > c) ? c : duty;
    p = (phase > c - 1) ? c - 1 : phase;
    if (m) begin
      r = (p + c - d / 2) % c;
      f = (p + (d + 1) / 2) % c;
    end else begin
      r = p;
      f = (p + d) % c;
    end
    full = (d == c);
  endtask

  always @(posedge CLK) begin : modelProc
    bit [CH_NUM-1:0] nxt;
    bit ready, accept, commit;
    int c, r, f;
    bit m, full;
    if (RST) begin
      mT = 0; mPrevT = 0; mCa = 2; mShdCa = 2; mIdx = 0; mCs = 2; mMs = 0;
      mDrainLeft = 0; mPending = 0; mPwm = '0;
      for (int i = 0; i < CH_NUM; i++) begin
        mShdR[i] = 0; mShdF[i] = 0; mShdFull[i] = 0;
        mActR[i] = 0; mActF[i] = 0; mActFull[i] = 0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) nxt[i] = pwmHigh(mActR[i], mActF[i], mActFull[i], mT, mCa);
      ready  = !mPending && (mDrainLeft == 0);
      accept = DIN_VALID && ready;
      commit = mPending && (SYNC || mT == mCa - 1);
      mPrevT = mT;
      mT = (SYNC || mT == mCa - 1) ? 0 : mT + 1;
      if (commit) begin
        for (int i = 0; i < CH_NUM; i++) begin
          mActR[i] = mShdR[i]; mActF[i] = mShdF[i]; mActFull[i] = mShdFull[i];
        end
        mCa = mShdCa;
        mPending = 0;
      end
      if (accept) begin
        if (mIdx == 0) begin
          mCs = int'(CYCLE); mMs = MODE; mShdCa = int'(CYCLE);
        end
        c = mCs; m = mMs;
        calcEdge(int'(DIN_DUTY), int'(DIN_PHASE), c, m, r, f, full);
        mShdR[mIdx] = r; mShdF[mIdx] = f; mShdFull[mIdx] = full;
        if (mIdx == CH_NUM - 1) begin
          mIdx = 0;
          mDrainLeft = 2;
        end else begin
          mIdx++;
        end
      end else if (mDrainLeft > 0) begin
        mDrainLeft--;
        if (mDrainLeft == 0) mPending = 1;
      end
      mPwm = nxt;
    end
  end

  // Every cycle, all observable outputs against the model.
  always @(negedge CLK) begin
    if (modelOn) begin
      checkOutput("TIME_CNT", TIME_CNT, mT);
      checkOutput("PWM_OUT", PWM_OUT, mPwm);
      checkOutput("DIN_READY", DIN_READY, !mPending && (mDrainLeft == 0));
      checkOutput("UPDATE_PENDING", UPDATE_PENDING, mPending);
    end
  end

  // ---------------- stimulus ----------------
  int frDuty [CH_NUM];
  int frPhase [CH_NUM];
  bit syncRand = 1'b0;

  always @(posedge CLK) begin
    #1;
    if (syncRand) SYNC = ($urandom_range(0, 39) == 0);
  end

  task automatic fillRandom(input int c);
    for (int i = 0; i < CH_NUM; i++) begin
      frDuty[i]  = $urandom_range(0, c + 2);
      frPhase[i] = $urandom_range(0, c + 2);
    end
  endtask

  task automatic applyStimulus(input int duty, input int phase, input int cyc, input bit mode);
    int waitCnt;
    bit rdy;
    waitCnt   = 0;
    DIN_VALID = 1'b1;
    DIN_DUTY  = WIDTH'(duty);
    DIN_PHASE = WIDTH'(phase);
    CYCLE     = WIDTH'(cyc);
    MODE      = mode;
    while (1) begin
      @(negedge CLK);
      rdy = DIN_READY;
      @(posedge CLK);
      #1;
      if (rdy) break;
      waitCnt++;
      if (waitCnt > 2000) begin
        checkOutput("beatTimeout", 1'b0, 1'b1);
        break;
      end
    end
    DIN_VALID = 1'b0;
    DIN_DUTY  = WIDTH'($urandom);
    DIN_PHASE = WIDTH'($urandom);
    CYCLE     = WIDTH'($urandom_range(2, 60));
    MODE      = 1'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic loadFrame(input int cyc, input bit mode, input int nBeats);
    for (int i = 0; i < nBeats; i++) begin
      if (i == 0) applyStimulus(frDuty[i], frPhase[i], cyc, mode);
      else        applyStimulus(frDuty[i], frPhase[i], $urandom_range(2, 60), 1'($urandom));
    end
  endtask

  task automatic waitPending();
    int n = 0;
    while (UPDATE_PENDING !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("pendingRise", UPDATE_PENDING, 1'b1);
  endtask

  task automatic waitCommit();
    int n = 0;
    while (UPDATE_PENDING !== 1'b0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("commitSeen", UPDATE_PENDING, 1'b0);
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; SYNC = 1'b0; DIN_VALID = 1'b0; DIN_DUTY = '0; DIN_PHASE = '0;
    CYCLE = WIDTH'(10); MODE = 1'b0;
    @(posedge CLK); #1;
    modelOn = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;

    // Idle after reset: counter toggles 0,1 with the reset period of 2.
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      checkOutput("idleCnt", TIME_CNT, k % 2);
      checkOutput("idleReady", DIN_READY, 1'b1);
      checkOutput("idlePwm", PWM_OUT, '0);
    end
    @(posedge CLK); #1;

    // Edge-aligned C=10, ch0 duty 3 phase 8: high for t in {8,9,0}.
    fillRandom(10);
    frDuty[0] = 3; frPhase[0] = 8;
    loadFrame(10, 1'b0, CH_NUM);
    waitPending();
    waitCommit();
    stepCycles(3);
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      checkOutput("edgeCh0", PWM_OUT[0], (mPrevT == 8 || mPrevT == 9 || mPrevT == 0));
    end
    @(posedge CLK); #1;

    // Center-aligned C=10: ch0 duty 5 phase 0, ch1 full duty, ch2 zero duty.
    fillRandom(10);
    frDuty[0] = 5;  frPhase[0] = 0;
    frDuty[1] = 10; frPhase[1] = 4;
    frDuty[2] = 0;  frPhase[2] = 6;
    loadFrame(10, 1'b1, CH_NUM);
    waitPending();
    waitCommit();
    stepCycles(3);
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      checkOutput("centerCh0", PWM_OUT[0], (mPrevT >= 8 || mPrevT <= 2));
      checkOutput("centerFull", PWM_OUT[1], 1'b1);
      checkOutput("centerZero", PWM_OUT[2], 1'b0);
    end
    @(posedge CLK); #1;

    // Back-to-back frames: the next frame's first beat is held through DRAIN/PENDING.
    fillRandom(10);
    loadFrame(10, 1'b0, CH_NUM);
    fillRandom(7);
    loadFrame(7, 1'b1, CH_NUM);
    waitPending();
    waitCommit();
    stepCycles(10);
    @(posedge CLK); #1;

    // Reset after 100 beats, then a complete replacement frame.
    fillRandom(20);
    loadFrame(20, 1'b0, 100);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("rstCnt", TIME_CNT, 0);
    checkOutput("rstPwm", PWM_OUT, '0);
    @(posedge CLK); #1;
    fillRandom(15);
    loadFrame(15, 1'b1, CH_NUM);
    waitPending();
    waitCommit();
    stepCycles(20);
    @(posedge CLK); #1;

    // SYNC while pending commits at once and zeroes the counter.
    fillRandom(60);
    loadFrame(60, 1'b0, CH_NUM);
    waitPending();
    @(posedge CLK); #1;
    if (UPDATE_PENDING === 1'b1) begin
      SYNC = 1'b1;
      @(posedge CLK); #1;
      SYNC = 1'b0;
      @(negedge CLK);
      checkOutput("syncCommit", UPDATE_PENDING, 1'b0);
      checkOutput("syncCnt", TIME_CNT, 0);
    end
    stepCycles(70);
    @(posedge CLK); #1;

    // Random frames with random SYNC pulses.
    syncRand = 1'b1;
    for (int fIdx = 0; fIdx < 3; fIdx++) begin
      int c;
      c = $urandom_range(2, 40);
      fillRandom(c);
      loadFrame(c, 1'($urandom), CH_NUM);
    end
    syncRand = 1'b0;
    SYNC = 1'b0;
    waitPending();
    waitCommit();
    stepCycles(90);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_seq_engine.md
# pwm_seq_engine

Next-generation PWM channel engine. A streamed loader computes rise/fall edges for `CH_NUM` channels one channel per beat, replacing a fully parallel preconditioner. Results are double-buffered and committed atomically at a period boundary. Supports edge- and center-aligned modes and a runtime-loadable common period. It sits between the host data path (duty/phase stream) and the transducer output pins.

## Interface

Parameters:
- `WIDTH`, 13: bit width of period, duty, phase and time count.
- `CH_NUM`, 249: number of PWM channels; frame length in beats.

Ports:
- `CLK`  in  1  system clock; only clock.
- `RST`  in  1  synchronous, active-high reset.
- `SYNC`  in  1  forces the time counter to 0 on the next cycle.
- `CYCLE`  in  WIDTH  period for the next frame; sampled on the first beat of a frame; legal range ≥2.
- `MODE`  in  1  0 = edge-aligned, 1 = center-aligned; sampled on the first beat.
- `DIN_VALID`  in  1  beat valid.
- `DIN_READY`  out  1  beat accepted when `DIN_VALID & DIN_READY`.
- `DIN_DUTY`  in  WIDTH  duty of the current channel.
- `DIN_PHASE`  in  WIDTH  phase of the current channel.
- `UPDATE_PENDING`  out  1  a complete frame is in shadow and awaits commit.
- `TIME_CNT`  out  WIDTH  shared period counter, 0..Ca-1, where Ca is the active period.
- `PWM_OUT[CH_NUM]`  out  1 each  registered PWM outputs.

## Operation

- FSM states: LOAD → DRAIN → PENDING → LOAD.
  - LOAD: `DIN_READY`=1; the channel index increments on each accepted beat.
  - The beat with index `CH_NUM`-1 moves the FSM to DRAIN and clears the index.
  - DRAIN: `DIN_READY`=0. Lasts until the last shadow write completes (2 cycles), then moves to PENDING with `UPDATE_PENDING`=1.
  - PENDING: waits for commit. On commit, moves to LOAD and clears `UPDATE_PENDING`.
- Edge computation is a 2-stage pipeline. Per beat, with C = sampled CYCLE:
  - D = min(duty, C).
  - P = min(phase, C-1).
  - Edge-aligned: rise = P, fall = (P + D) mod C.
  - Center-aligned: rise = (P + C - ⌊D/2⌋) mod C, fall = (P + ⌈D/2⌉) mod C.
  - `mod` is a single conditional subtraction; all operands are < 2C.
  - full = (D == C).
  - Intermediate sums use WIDTH+1 bits.
- Shadow registers per channel: rise, fall, full. A shadow period register is also kept.
- Commit happens on the cycle where the counter is about to become 0, i.e. `TIME_CNT` == Ca-1 or `SYNC`=1, and the FSM is in PENDING. On commit, active ← shadow for all channels and Ca ← shadow period, simultaneously.
- Counter behaviour:
  - `SYNC` has priority and loads 0.
  - Otherwise the counter wraps at Ca-1, else increments.
  - A period change applies from the count value 0 after commit.
- Output rule, with t = `TIME_CNT`:
  - full → 1.
  - rise == fall → 0.
  - rise < fall → rise ≤ t < fall.
  - rise > fall → t ≥ rise or t < fall.

## Timing

- Reset values:
  - `TIME_CNT`=0.
  - `PWM_OUT`=0 for all channels.
  - `UPDATE_PENDING`=0.
  - FSM=LOAD, so `DIN_READY`=1 in the first cycle after reset.
  - Channel index 0.
  - Active and shadow rise/fall/full = 0.
  - Ca = 2.
- `PWM_OUT[i]` at cycle n+1 reflects `TIME_CNT` and active values at cycle n; latency is 1 cycle.
- Beat accepted at cycle t: the shadow write completes at the end of cycle t+2.
- `UPDATE_PENDING` rises 3 cycles after acceptance of the final beat.
- Commit cycle c: the new edges are visible on `PWM_OUT` at c+2, aligned with `TIME_CNT`=0 at c+1.
- `RST` mid-frame: the partial shadow is discarded, the index returns to 0, and all registers take their reset values.
- `DIN_VALID` while `DIN_READY`=0 is ignored. The source must hold the beat.
- `SYNC` in PENDING commits immediately. `SYNC` in LOAD or DRAIN only zeroes the counter.

## Structure

- A shared package `pwm_seq_pkg` holds:
  - the FSM state enum;
  - `typedef struct {rise, fall, full}` edge type, parametrised by WIDTH.
- Sub-module `pwm_edge_calc` is the 2-stage pipelined edge arithmetic, with WIDTH as a parameter.
- Per-channel output comparison is a generate loop in the top module.

## Test plan

- Reset, then idle: `PWM_OUT` all 0, `TIME_CNT` counts 0,1,0,1 (Ca=2), `DIN_READY`=1.
- Edge-aligned frame, CYCLE=10, duty=3, phase=8 on channel 0 → rise=8, fall=1; after commit `PWM_OUT[0]` is high for t ∈ {8,9,0}.
- Center-aligned, CYCLE=10, duty=5, phase=0 → rise=8, fall=3.
- Center-aligned, duty=10 → output constantly 1.
- Center-aligned, duty=0 → output constantly 0.
- Frame completes mid-period at t=4 with Ca=10: `UPDATE_PENDING`=1; `DIN_READY`=0 until commit at t=9; the new values take effect from t=0; a `DIN_VALID` beat held during PENDING is accepted only after commit.
- `RST` asserted after 100 of 249 beats, then a full new frame → only the new frame's values are committed. `SYNC` during PENDING → immediate commit and counter to 0.
